master_bridge_fifo_rd_arbiter: RTL and testbench
================================================

# master_bridge_fifo_rd_arbiter

Read-side scheduler for the master bridge's clock-crossing FIFOs. It sits in the R_CLK domain, between NUM_FIFOS async-FIFO read ports and the single downstream request channel of the AXI master. It round-robins between non-empty FIFOs and holds each grant for a whole packet, so packets stay atomic. It drives each FIFO's `rd_inc` and presents popped words on a registered valid/ready output.

## Interface
- NUM_FIFOS, 3, number of FIFO read ports arbitrated (1..8)
- DATA_WIDTH, 32, payload bits per FIFO word (excluding last flag)
- SRC_WIDTH, 2, width of source index, must satisfy 2^SRC_WIDTH >= NUM_FIFOS
- R_CLK  in  1  read-domain clock
- R_RST  in  1  reset, asynchronous, active-low
- fifo_empty  in  NUM_FIFOS  per-FIFO `rd_empty`
- fifo_rd_data  in  NUM_FIFOS*(DATA_WIDTH+1)  per-FIFO word at current read address; slice i = bits [i*(DATA_WIDTH+1) +: DATA_WIDTH+1], MSB of slice = last flag
- fifo_rd_inc  out  NUM_FIFOS  per-FIFO pop strobe (`rd_inc`)
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_data  out  DATA_WIDTH  payload of popped word
- out_last  out  1  last flag of popped word
- out_src  out  SRC_WIDTH  index of FIFO the word came from
- busy  out  1  high while state is XFER

## Operation
- FSM states IDLE, XFER; registers grant (SRC_WIDTH), prio pointer (SRC_WIDTH), output register {out_valid, out_data, out_last, out_src}.
- IDLE: if any fifo_empty bit is 0, select first non-empty index searching upward from prio, wrapping modulo NUM_FIFOS. Latch grant = index; go to XFER. No pop in IDLE. If all empty, stay.
- XFER: load = ~fifo_empty[grant] & (~out_valid | out_ready).
  - fifo_rd_inc[grant] = load; all other fifo_rd_inc bits 0; all bits 0 outside XFER.
  - On load: out_data/out_last from slice grant, out_src = grant, out_valid = 1.
  - On load with last flag = 1: go to IDLE; prio = (grant+1 == NUM_FIFOS) ? 0 : grant+1.
- out_valid clears when out_ready & out_valid & ~load. Output fields are held stable while out_valid & ~out_ready.
- Empty mid-packet: stay in XFER with grant held, no pop, and no switch to another FIFO. Wait indefinitely.
- Only an entry with last flag = 1 ends a grant. A FIFO emptying does not end it.
- IDLE arbitration may overlap a pending (unaccepted) output word.
- NUM_FIFOS = 1: grant and prio are always 0; the behaviour is otherwise identical.
- Reset (any time, including mid-packet): state IDLE, grant 0, prio 0, out_valid 0, out_data 0, out_last 0, out_src 0, fifo_rd_inc 0, busy 0. A partial packet is not resumed; recovery is handled at system level by resetting both FIFO sides together.

## Timing
- fifo_rd_inc is combinational from state, grant, fifo_empty, out_valid and out_ready. It is never asserted for an empty FIFO.
- Latency: fifo_empty[i] falls in cycle 0 with the FSM in IDLE → grant in cycle 1 (XFER) → pop in cycle 1 → out_valid high from cycle 2.
- Throughput: 1 word/cycle within a packet while out_ready = 1 and the FIFO is non-empty.
- Inter-packet gap: exactly 1 IDLE cycle with no pop.
- busy = (state == XFER), registered.

## Test plan
- Single 3-word packet (last on word 3) in FIFO 0, others empty, out_ready = 1 → fifo_rd_inc[0] high for 3 consecutive cycles starting 1 cycle after FIFO 0 goes non-empty; out_src = 0; out_last only on word 3; FSM then returns to IDLE.
- All 3 FIFOs each hold two 1-word packets, prio = 0 → output out_src order 0,1,2,0,1,2, with a 1-cycle gap between packets.
- Backpressure: out_ready = 0 for 4 cycles mid-packet → at most one pop, then fifo_rd_inc = 0; out_data and out_valid stable. Release out_ready → streaming resumes with no word lost or duplicated.
- FIFO 1 empties after word 2 of a 4-word packet while FIFO 2 is non-empty → grant stays on 1 and no FIFO-2 pop occurs until FIFO 1 delivers words 3–4.
- Assert R_RST during word 2 of a packet → all outputs 0 and fifo_rd_inc = 0 in the same cycle. After release, arbitration restarts from prio = 0.
- NUM_FIFOS = 1, back-to-back 2-word packets → pops on cycles 1,2 and 4,5; out_src always 0.

Source files
------------

// File: rtl/master_bridge_fifo_rd_arbiter.sv
// Read-side scheduler for the master bridge clock-crossing FIFOs: round-robin
// between non-empty FIFOs, holding each grant until a last-flagged word pops.
module master_bridge_fifo_rd_arbiter #(
  parameter int NUM_FIFOS  = 3,
  parameter int DATA_WIDTH = 32,
  parameter int SRC_WIDTH  = 2
) (
  input  logic                                R_CLK,
  input  logic                                R_RST,
  input  logic [NUM_FIFOS-1:0]                fifo_empty,
  input  logic [NUM_FIFOS*(DATA_WIDTH+1)-1:0] fifo_rd_data,
  output logic [NUM_FIFOS-1:0]                fifo_rd_inc,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_last,
  output logic [SRC_WIDTH-1:0]                out_src,
  output logic                                busy
);

  localparam int SLOTS  = 1 << SRC_WIDTH;
  localparam int WORD_W = DATA_WIDTH + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]           state;
  logic [SRC_WIDTH-1:0] grant;
  logic [SRC_WIDTH-1:0] prio;
  logic [SRC_WIDTH-1:0] pick;
  logic                 any_ready;
  logic                 load;
  logic [WORD_W-1:0]    cur_word;

  logic                 empty_slot [SLOTS];
  logic [WORD_W-1:0]    word_slot  [SLOTS];

  function automatic logic [SRC_WIDTH-1:0] next_src(input logic [SRC_WIDTH-1:0] src);
    if (int'(src) + 1 >= NUM_FIFOS) return '0;
    return src + SRC_WIDTH'(1);
  endfunction

  // Pad the port arrays out to the full index range so grant can index them
  // directly; unused slots look permanently empty.
  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    if (g < NUM_FIFOS) begin : g_used
      assign empty_slot[g] = fifo_empty[g];
      assign word_slot[g]  = fifo_rd_data[g*WORD_W +: WORD_W];
    end else begin : g_pad
      assign empty_slot[g] = 1'b1;
      assign word_slot[g]  = '0;
    end
  end

  // Scan downward in offset so the nearest non-empty FIFO at or after prio wins.
  always_comb begin
    int                   idx;
    logic [SRC_WIDTH-1:0] sel;
    pick      = prio;
    any_ready = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
      idx = int'(prio) + k;
      if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
      sel = SRC_WIDTH'(idx);
      if (!empty_slot[sel]) begin
        pick      = sel;
        any_ready = 1'b1;
      end
    end
  end

  assign cur_word = word_slot[grant];
  assign load     = (state == XFER) && !empty_slot[grant] && (!out_valid || out_ready);
  assign busy     = (state == XFER);

  always_comb begin
    fifo_rd_inc = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (grant == SRC_WIDTH'(i)) fifo_rd_inc[i] = load;
    end
  end

  // Arbitration / grant-hold state
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      state <= IDLE;
      grant <= '0;
      prio  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_ready) begin
            grant <= pick;
            state <= XFER;
          end
        end
        XFER: begin
          if (load && cur_word[WORD_W-1]) begin
            state <= IDLE;
            prio  <= next_src(grant);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: fields only change on a new load, so they stay put under backpressure
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= cur_word[DATA_WIDTH-1:0];
      out_last  <= cur_word[WORD_W-1];
      out_src   <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_master_bridge_fifo_rd_arbiter.sv
// Directed bench for master_bridge_fifo_rd_arbiter: a 3-FIFO instance and a
// 1-FIFO instance, each fed by a small pointer-based FIFO model.
module tb_master_bridge_fifo_rd_arbiter;

  localparam int NF = 3;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int WW = DW + 1;

  localparam logic [63:0] T2_SRC  [6] = '{64'd0, 64'd1, 64'd2, 64'd0, 64'd1, 64'd2};
  localparam logic [63:0] T2_DATA [6] = '{64'hB00, 64'hB10, 64'hB20, 64'hB01, 64'hB11, 64'hB21};
  localparam logic [63:0] T6_INC  [6] = '{64'd1, 64'd1, 64'd0, 64'd1, 64'd1, 64'd0};
  localparam logic [63:0] T6_VLD  [6] = '{64'd0, 64'd1, 64'd1, 64'd0, 64'd1, 64'd1};
  localparam logic [63:0] T6_DATA [6] = '{64'd0, 64'h70, 64'h71, 64'd0, 64'h72, 64'h73};
  localparam logic [63:0] T6_LAST [6] = '{64'd0, 64'd0, 64'd1, 64'd0, 64'd0, 64'd1};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NF-1:0]     fifo_empty;
  logic [NF-1:0]     fifo_rd_inc;
  logic [NF*WW-1:0]  fifo_rd_data;
  logic              out_valid, out_ready, out_last, busy;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_src;

  logic              empty1, inc1, valid1, ready1, last1, busy1;
  logic [WW-1:0]     data_in1;
  logic [DW-1:0]     data1;
  logic [0:0]        src1;

  logic [WW-1:0]     mem  [NF][32];
  logic [4:0]        rptr [NF];
  logic [4:0]        wptr [NF];
  logic [WW-1:0]     mem1 [32];
  logic [4:0]        rptr1, wptr1;
  logic              flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  master_bridge_fifo_rd_arbiter #(.NUM_FIFOS(NF), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) dut (
    .R_CLK(clk), .R_RST(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_inc(fifo_rd_inc), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_src(out_src), .busy(busy)
  );

  master_bridge_fifo_rd_arbiter #(.NUM_FIFOS(1), .DATA_WIDTH(DW), .SRC_WIDTH(1)) dut1 (
    .R_CLK(clk), .R_RST(rst_n), .fifo_empty(empty1), .fifo_rd_data(data_in1),
    .fifo_rd_inc(inc1), .out_valid(valid1), .out_ready(ready1),
    .out_data(data1), .out_last(last1), .out_src(src1), .busy(busy1)
  );

  always_comb begin
    for (int f = 0; f < NF; f++) begin
      fifo_empty[f]             = (rptr[f] == wptr[f]);
      fifo_rd_data[f*WW +: WW]  = mem[f][rptr[f]];
    end
  end
  assign empty1   = (rptr1 == wptr1);
  assign data_in1 = mem1[rptr1];

  always @(posedge clk) begin
    for (int f = 0; f < NF; f++) begin
      if (flush) rptr[f] <= wptr[f];
      else if (fifo_rd_inc[f]) rptr[f] <= rptr[f] + 5'd1;
    end
    if (flush) rptr1 <= wptr1;
    else if (inc1) rptr1 <= rptr1 + 5'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int f, input logic last, input logic [DW-1:0] d);
    mem[f][wptr[f]] = {last, d};
    wptr[f] = wptr[f] + 5'd1;
  endtask

  task automatic push1(input logic last, input logic [DW-1:0] d);
    mem1[wptr1] = {last, d};
    wptr1 = wptr1 + 5'd1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; ready1 = 1'b1; flush = 1'b1;
    for (int f = 0; f < NF; f++) wptr[f] = 5'd0;
    wptr1 = 5'd0;
    tick(); tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_last",  64'(out_last),  64'd0);
    chk("rst_src",   64'(out_src),   64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_inc",   64'(fifo_rd_inc), 64'd0);
    chk("rst_valid1", 64'(valid1),   64'd0);
    rst_n = 1'b1; flush = 1'b0;

    // single 3-word packet in FIFO 0
    push(0, 1'b0, 32'hA0); push(0, 1'b0, 32'hA1); push(0, 1'b1, 32'hA2);
    #1 chk("t1_c0_inc", 64'(fifo_rd_inc), 64'd0);
    tick();
    chk("t1_c1_inc",   64'(fifo_rd_inc), 64'd1);
    chk("t1_c1_busy",  64'(busy),        64'd1);
    chk("t1_c1_valid", 64'(out_valid),   64'd0);
    tick();
    chk("t1_c2_valid", 64'(out_valid),   64'd1);
    chk("t1_c2_data",  64'(out_data),    64'hA0);
    chk("t1_c2_last",  64'(out_last),    64'd0);
    chk("t1_c2_src",   64'(out_src),     64'd0);
    chk("t1_c2_inc",   64'(fifo_rd_inc), 64'd1);
    tick();
    chk("t1_c3_data",  64'(out_data),    64'hA1);
    chk("t1_c3_last",  64'(out_last),    64'd0);
    chk("t1_c3_inc",   64'(fifo_rd_inc), 64'd1);
    tick();
    chk("t1_c4_data",  64'(out_data),    64'hA2);
    chk("t1_c4_last",  64'(out_last),    64'd1);
    chk("t1_c4_busy",  64'(busy),        64'd0);
    chk("t1_c4_inc",   64'(fifo_rd_inc), 64'd0);
    tick();
    chk("t1_c5_valid", 64'(out_valid),   64'd0);

    // reset to bring prio back to 0, then round-robin over 1-word packets
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int f = 0; f < NF; f++) push(f, 1'b1, 32'(32'hB00 + f * 16 + p));
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t2_gap_valid", 64'(out_valid), 64'd0);
      chk("t2_gap_busy",  64'(busy),      64'd1);
      tick();
      chk("t2_valid", 64'(out_valid),   64'd1);
      chk("t2_src",   64'(out_src),     T2_SRC[k]);
      chk("t2_data",  64'(out_data),    T2_DATA[k]);
      chk("t2_idle",  64'(busy),        64'd0);
      chk("t2_noinc", 64'(fifo_rd_inc), 64'd0);
    end
    tick();
    chk("t2_end_valid", 64'(out_valid), 64'd0);

    // backpressure mid-packet
    push(0, 1'b0, 32'hC0); push(0, 1'b0, 32'hC1); push(0, 1'b0, 32'hC2); push(0, 1'b1, 32'hC3);
    tick();
    chk("t3_c1_inc", 64'(fifo_rd_inc), 64'd1);
    tick();
    chk("t3_c2_data", 64'(out_data), 64'hC0);
    out_ready = 1'b0;
    #1 chk("t3_stall_inc0", 64'(fifo_rd_inc), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_stall_valid", 64'(out_valid),   64'd1);
      chk("t3_stall_data",  64'(out_data),    64'hC0);
      chk("t3_stall_inc",   64'(fifo_rd_inc), 64'd0);
    end
    out_ready = 1'b1;
    #1 chk("t3_resume_inc", 64'(fifo_rd_inc), 64'd1);
    tick();
    chk("t3_c6_data", 64'(out_data), 64'hC1);
    tick();
    chk("t3_c7_data", 64'(out_data), 64'hC2);
    tick();
    chk("t3_c8_data", 64'(out_data), 64'hC3);
    chk("t3_c8_last", 64'(out_last), 64'd1);
    tick();
    chk("t3_c9_valid", 64'(out_valid), 64'd0);

    // FIFO 1 runs dry mid-packet while FIFO 2 waits
    push(1, 1'b0, 32'hD0); push(1, 1'b0, 32'hD1); push(2, 1'b1, 32'hE0);
    tick();
    chk("t4_c1_inc", 64'(fifo_rd_inc), 64'd2);
    tick();
    chk("t4_c2_data", 64'(out_data), 64'hD0);
    chk("t4_c2_src",  64'(out_src),  64'd1);
    tick();
    chk("t4_c3_data", 64'(out_data),    64'hD1);
    chk("t4_c3_inc",  64'(fifo_rd_inc), 64'd0);
    chk("t4_c3_busy", 64'(busy),        64'd1);
    tick();
    chk("t4_c4_valid", 64'(out_valid),   64'd0);
    chk("t4_c4_inc",   64'(fifo_rd_inc), 64'd0);
    tick();
    chk("t4_c5_inc",  64'(fifo_rd_inc), 64'd0);
    chk("t4_c5_busy", 64'(busy),        64'd1);
    push(1, 1'b0, 32'hD2); push(1, 1'b1, 32'hD3);
    #1 chk("t4_refill_inc", 64'(fifo_rd_inc), 64'd2);
    tick();
    chk("t4_c6_data", 64'(out_data), 64'hD2);
    chk("t4_c6_src",  64'(out_src),  64'd1);
    tick();
    chk("t4_c7_data", 64'(out_data),    64'hD3);
    chk("t4_c7_last", 64'(out_last),    64'd1);
    chk("t4_c7_inc",  64'(fifo_rd_inc), 64'd0);
    tick();
    chk("t4_c8_inc", 64'(fifo_rd_inc), 64'd4);
    tick();
    chk("t4_c9_src",  64'(out_src),  64'd2);
    chk("t4_c9_data", 64'(out_data), 64'hE0);

    // reset in the middle of a FIFO 2 packet, with prio moved to 1 beforehand
    push(0, 1'b1, 32'h40);
    push(2, 1'b0, 32'hF0); push(2, 1'b0, 32'hF1); push(2, 1'b1, 32'hF2);
    tick();
    chk("t5_c1_inc", 64'(fifo_rd_inc), 64'd1);
    tick();
    chk("t5_c2_data", 64'(out_data), 64'h40);
    tick();
    chk("t5_c3_inc", 64'(fifo_rd_inc), 64'd4);
    tick();
    chk("t5_c4_data", 64'(out_data), 64'hF0);
    tick();
    chk("t5_c5_data", 64'(out_data), 64'hF1);
    rst_n = 1'b0; flush = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(out_valid),   64'd0);
    chk("t5_rst_data",  64'(out_data),    64'd0);
    chk("t5_rst_last",  64'(out_last),    64'd0);
    chk("t5_rst_src",   64'(out_src),     64'd0);
    chk("t5_rst_busy",  64'(busy),        64'd0);
    chk("t5_rst_inc",   64'(fifo_rd_inc), 64'd0);
    tick();
    rst_n = 1'b1; flush = 1'b0;
    push(0, 1'b1, 32'h50); push(1, 1'b1, 32'h51);
    tick();
    chk("t5_after_inc", 64'(fifo_rd_inc), 64'd1);
    tick();
    chk("t5_after_src0",  64'(out_src),  64'd0);
    chk("t5_after_data0", 64'(out_data), 64'h50);
    tick();
    chk("t5_after_inc1", 64'(fifo_rd_inc), 64'd2);
    tick();
    chk("t5_after_src1",  64'(out_src),  64'd1);
    chk("t5_after_data1", 64'(out_data), 64'h51);

    // single-FIFO instance, back-to-back 2-word packets
    push1(1'b0, 32'h70); push1(1'b1, 32'h71); push1(1'b0, 32'h72); push1(1'b1, 32'h73);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t6_inc",   64'(inc1),   T6_INC[k]);
      chk("t6_valid", 64'(valid1), T6_VLD[k]);
      chk("t6_src",   64'(src1),   64'd0);
      if (T6_VLD[k] == 64'd1) begin
        chk("t6_data", 64'(data1), T6_DATA[k]);
        chk("t6_last", 64'(last1), T6_LAST[k]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
